// File: rtl/accum_arbiter.sv
// accum_arbiter: N requesters share one accumulator through a round-robin
// grant and an IDLE -> CHECK -> (ADD) -> ACK transaction sequence.
// Values at or below threshold are dropped and counted instead of being added.
//
// Ports:
//   CLK, RST    clock and synchronous active-high reset
//   enable      permits new grants from IDLE
//   req         per-requester request, held until ack
//   req_value   packed request values, requester i at [i*W +: W]
//   threshold   values <= threshold are dropped
//   ack         one-hot completion pulse during ACK
//   grant_id    index of current / last granted requester
//   busy        high whenever the sequencer is not in IDLE
//   count       running modular sum of accepted values
//   drop_cnt    saturating count of dropped requests
//   led         registered display of count, one cycle behind it
module accum_arbiter #(
   parameter int unsigned N       = 4,
   parameter int unsigned W       = 8,
   parameter int unsigned COUNT_W = 32,
   localparam int unsigned GID_W  = (N > 1) ? $clog2(N) : 1
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               enable,
   input  logic [N-1:0]       req,
   input  logic [N*W-1:0]     req_value,
   input  logic [W-1:0]       threshold,
   output logic [N-1:0]       ack,
   output logic [GID_W-1:0]   grant_id,
   output logic               busy,
   output logic [COUNT_W-1:0] count,
   output logic [7:0]         drop_cnt,
   output logic [7:0]         led
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CHECK = 2'd1;
   localparam logic [1:0] S_ADD   = 2'd2;
   localparam logic [1:0] S_ACK   = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [GID_W-1:0]   gid_q, gid_d;
   logic [GID_W-1:0]   ptr_q, ptr_d;
   logic [W-1:0]       val_q, val_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic [7:0]         drop_q, drop_d;
   logic [N-1:0]       ack_q, ack_d;
   logic               busy_q, busy_d;
   logic [7:0]         led_q, led_d;

   logic [W-1:0]       vals [N];
   logic               found_c;
   logic [GID_W-1:0]   pick_c;

   // Unpack the request value bus.
   for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign vals[gi] = req_value[gi*W +: W];
   end

   // Round-robin pick: first set request scanning upward from ptr_q.
   always_comb begin
      logic [GID_W-1:0] idx;
      found_c = 1'b0;
      pick_c  = '0;
      idx     = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = GID_W'((32'(ptr_q) + k) % N);
         if (!found_c && req[idx]) begin
            found_c = 1'b1;
            pick_c  = idx;
         end
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      gid_d   = gid_q;
      ptr_d   = ptr_q;
      val_d   = val_q;
      count_d = count_q;
      drop_d  = drop_q;
      ack_d   = '0;

      case (state_q)
         S_IDLE: begin
            if (enable && found_c) begin
               gid_d   = pick_c;
               val_d   = vals[pick_c];
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (val_q > threshold) begin
               state_d = S_ADD;
            end else begin
               if (drop_q != 8'hFF) begin
                  drop_d = drop_q + 8'd1;
               end
               ack_d[gid_q] = 1'b1;
               state_d      = S_ACK;
            end
         end
         S_ADD: begin
            count_d      = count_q + COUNT_W'(val_q);
            ack_d[gid_q] = 1'b1;
            state_d      = S_ACK;
         end
         S_ACK: begin
            // Pointer moves just past the requester that was served.
            ptr_d   = (gid_q == GID_W'(N - 1)) ? '0 : gid_q + GID_W'(1);
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
      // Show the upper byte once the sum has grown past 16 bits.
      led_d  = (count_q[COUNT_W-1:16] != '0) ? count_q[23:16] : count_q[7:0];
   end

   // State and datapath registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         gid_q   <= '0;
         ptr_q   <= '0;
         val_q   <= '0;
         count_q <= '0;
         drop_q  <= '0;
         ack_q   <= '0;
         busy_q  <= 1'b0;
         led_q   <= '0;
      end else begin
         state_q <= state_d;
         gid_q   <= gid_d;
         ptr_q   <= ptr_d;
         val_q   <= val_d;
         count_q <= count_d;
         drop_q  <= drop_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         led_q   <= led_d;
      end
   end

   assign ack      = ack_q;
   assign grant_id = gid_q;
   assign busy     = busy_q;
   assign count    = count_q;
   assign drop_cnt = drop_q;
   assign led      = led_q;

endmodule
